// File: rtl/input_buffer_ctrl.sv
// Input buffer controller: loads a row stream into a single-port buffer, then reads rows back.
// Optional macro INBUF_RETN_GATE_EN: retention off in IDLE plus a one-cycle WAKE state.
module input_buffer_ctrl #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              buf_cen,
  output logic              buf_wen,
  output logic              buf_retn,
  output logic [ADDR_W-1:0] buf_a,
  output logic [DATA_W-1:0] buf_d,
  input  logic [DATA_W-1:0] buf_q,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_FLUSH,
    S_DONE,
    S_WAKE
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W:0]   r_load_len;
  logic [ADDR_W:0]   r_rd_len;
  logic [ADDR_W-1:0] r_rd_base;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_cnt;
  logic              r_rd_valid;

  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W:0]   w_wr_inc;
  logic [ADDR_W:0]   w_rd_inc;
  logic [ADDR_W-1:0] w_rd_a;
  logic              w_launch;

  function automatic state_t first_st(
    input logic [ADDR_W:0] ll,
    input logic [ADDR_W:0] rl
  );
    if (ll != '0)      return S_LOAD;
    else if (rl != '0) return S_READ;
    else               return S_DONE;
  endfunction

  assign w_wr     = (r_state == S_LOAD) && wr_valid;
  assign w_rd     = (r_state == S_READ) && rd_req;
  assign w_wr_inc = r_wr_ptr + ONE;
  assign w_rd_inc = r_rd_cnt + ONE;
  assign w_rd_a   = r_rd_base + r_rd_cnt[ADDR_W-1:0];
  assign w_launch = (r_state == S_IDLE) && start;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef INBUF_RETN_GATE_EN
          w_nxt = S_WAKE;
`else
          w_nxt = first_st(load_len, rd_len);
`endif
        end
      end
      S_WAKE:  w_nxt = first_st(r_load_len, r_rd_len);
      S_LOAD: begin
        if (w_wr && (w_wr_inc == r_load_len))
          w_nxt = (r_rd_len != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        if (w_rd && (w_rd_inc == r_rd_len))
          w_nxt = S_FLUSH;
      end
      S_FLUSH: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (r_state == S_LOAD);
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    buf_cen  = !(w_wr || w_rd);
    buf_wen  = !w_wr;
    buf_a    = '0;
    buf_d    = '0;
    if (w_wr) begin
      buf_a = r_wr_ptr[ADDR_W-1:0];
      buf_d = wr_data;
    end else if (w_rd) begin
      buf_a = w_rd_a;
    end
`ifdef INBUF_RETN_GATE_EN
    buf_retn = (r_state != S_IDLE);
`else
    buf_retn = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_load_len <= '0;
      r_rd_len   <= '0;
      r_rd_base  <= '0;
      r_wr_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_launch) begin
        r_load_len <= load_len;
        r_rd_len   <= rd_len;
        r_rd_base  <= rd_base;
        r_wr_ptr   <= '0;
        r_rd_cnt   <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= w_wr_inc;
        if (w_rd) r_rd_cnt <= w_rd_inc;
      end
      r_rd_valid <= w_rd;
    end
  end

  // Buffer read data is registered, so it lines up with the delayed valid.
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_valid ? buf_q : '0;

endmodule
